// File: rtl/id_ex_stage_pkg.sv
// Shared widths, instruction field offsets and control-bit indices for the
// ID->EX pipeline boundary.
package id_ex_stage_pkg;

  localparam int NB_DATA  = 32;
  localparam int NB_ADDR  = 5;
  localparam int NB_ALUOP = 4;

  localparam int NB_INSTR = 32;
  localparam int NB_IMM   = 16;
  localparam int NB_SHAMT = 5;

  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int IMM_LSB   = 0;

  localparam int NB_CTRL_WB  = 2;
  localparam int NB_CTRL_MEM = 2;

  localparam int CTRL_WB_REG_WRITE  = 1;
  localparam int CTRL_WB_MEM_TO_REG = 0;
  localparam int CTRL_MEM_READ      = 1;
  localparam int CTRL_MEM_WRITE     = 0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: the instruction in ID reads the register that the
// load currently in EX has not yet produced. A taken branch cancels it.
module hazard_detect #(
  parameter int NB_ADDR = 5
) (
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [NB_ADDR-1:0] i_id_rs,
  input  logic [NB_ADDR-1:0] i_id_rt,
  input  logic               i_uses_rt,
  input  logic               i_ex_valid,
  input  logic               i_ex_mem_read,
  input  logic [NB_ADDR-1:0] i_ex_rt,
  output logic               o_stall
);

  logic w_rt_live;
  logic w_match;

  // $0 is hardwired, so a load targeting it never creates a dependency
  assign w_rt_live = (i_ex_rt != '0);
  assign w_match   = (i_ex_rt == i_id_rs) | (i_uses_rt & (i_ex_rt == i_id_rt));
  assign o_stall   = ~i_flush & i_valid & i_ex_valid & i_ex_mem_read &
                     w_rt_live & w_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register of the 5-stage MIPS core, with load-use stall,
// branch flush and debug step enable.
module id_ex_stage #(
  parameter int NB_DATA  = id_ex_stage_pkg::NB_DATA,
  parameter int NB_ADDR  = id_ex_stage_pkg::NB_ADDR,
  parameter int NB_ALUOP = id_ex_stage_pkg::NB_ALUOP
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [NB_DATA-1:0]    i_data_rs,
  input  logic [NB_DATA-1:0]    i_data_rt,
  input  logic [31:0]           i_instr,
  input  logic [31:0]           i_pc_next,
  input  logic                  i_uses_rt,
  input  logic                  i_imm_zext,
  input  logic [1:0]            i_ctrl_wb,
  input  logic [1:0]            i_ctrl_mem,
  input  logic [3+NB_ALUOP-1:0] i_ctrl_ex,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [NB_DATA-1:0]    o_data_rs,
  output logic [NB_DATA-1:0]    o_data_rt,
  output logic [NB_DATA-1:0]    o_imm,
  output logic [NB_ADDR-1:0]    o_rs,
  output logic [NB_ADDR-1:0]    o_rt,
  output logic [NB_ADDR-1:0]    o_rd,
  output logic [4:0]            o_shamt,
  output logic [31:0]           o_pc_next,
  output logic [1:0]            o_ctrl_wb,
  output logic [1:0]            o_ctrl_mem,
  output logic [3+NB_ALUOP-1:0] o_ctrl_ex
);

  import id_ex_stage_pkg::*;

  localparam int NB_CTRL_EX = 3 + NB_ALUOP;

  logic                  r_valid;
  logic [NB_DATA-1:0]    r_data_rs;
  logic [NB_DATA-1:0]    r_data_rt;
  logic [NB_DATA-1:0]    r_imm;
  logic [NB_ADDR-1:0]    r_rs;
  logic [NB_ADDR-1:0]    r_rt;
  logic [NB_ADDR-1:0]    r_rd;
  logic [4:0]            r_shamt;
  logic [31:0]           r_pc_next;
  logic [1:0]            r_ctrl_wb;
  logic [1:0]            r_ctrl_mem;
  logic [NB_CTRL_EX-1:0] r_ctrl_ex;

  logic                  w_stall;
  logic                  w_load;
  logic [NB_IMM-1:0]     w_imm16;
  logic [NB_DATA-1:0]    w_imm_ext;
  logic [NB_ADDR-1:0]    w_id_rs;
  logic [NB_ADDR-1:0]    w_id_rt;
  logic                  w_unused_bits;

  assign w_id_rs = i_instr[RS_LSB +: NB_ADDR];
  assign w_id_rt = i_instr[RT_LSB +: NB_ADDR];
  assign w_imm16 = i_instr[IMM_LSB +: NB_IMM];
  assign w_imm_ext = i_imm_zext ? {{(NB_DATA-NB_IMM){1'b0}}, w_imm16}
                                : {{(NB_DATA-NB_IMM){w_imm16[NB_IMM-1]}}, w_imm16};

  // Opcode and funct are consumed by the decoder, not by this stage
  assign w_unused_bits = ^{i_instr[31:26], i_instr[5:0]};

  hazard_detect #(
    .NB_ADDR (NB_ADDR)
  ) u_hazard_detect (
    .i_flush       (i_flush),
    .i_valid       (i_valid),
    .i_id_rs       (w_id_rs),
    .i_id_rt       (w_id_rt),
    .i_uses_rt     (i_uses_rt),
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl_mem[CTRL_MEM_READ]),
    .i_ex_rt       (r_rt),
    .o_stall       (w_stall)
  );

  // Flush, stall and an empty ID slot all collapse to a fully cleared bubble
  assign w_load = i_valid & ~i_flush & ~w_stall;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid    <= 1'b0;
      r_data_rs  <= '0;
      r_data_rt  <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_shamt    <= '0;
      r_pc_next  <= '0;
      r_ctrl_wb  <= '0;
      r_ctrl_mem <= '0;
      r_ctrl_ex  <= '0;
    end else if (i_enable) begin
      if (w_load) begin
        r_valid    <= 1'b1;
        r_data_rs  <= i_data_rs;
        r_data_rt  <= i_data_rt;
        r_imm      <= w_imm_ext;
        r_rs       <= w_id_rs;
        r_rt       <= w_id_rt;
        r_rd       <= i_instr[RD_LSB +: NB_ADDR];
        r_shamt    <= i_instr[SHAMT_LSB +: NB_SHAMT];
        r_pc_next  <= i_pc_next;
        r_ctrl_wb  <= i_ctrl_wb;
        r_ctrl_mem <= i_ctrl_mem;
        r_ctrl_ex  <= i_ctrl_ex;
      end else begin
        r_valid    <= 1'b0;
        r_data_rs  <= '0;
        r_data_rt  <= '0;
        r_imm      <= '0;
        r_rs       <= '0;
        r_rt       <= '0;
        r_rd       <= '0;
        r_shamt    <= '0;
        r_pc_next  <= '0;
        r_ctrl_wb  <= '0;
        r_ctrl_mem <= '0;
        r_ctrl_ex  <= '0;
      end
    end
  end

  assign o_stall    = w_stall;
  assign o_valid    = r_valid;
  assign o_data_rs  = r_data_rs;
  assign o_data_rt  = r_data_rt;
  assign o_imm      = r_imm;
  assign o_rs       = r_rs;
  assign o_rt       = r_rt;
  assign o_rd       = r_rd;
  assign o_shamt    = r_shamt;
  assign o_pc_next  = r_pc_next;
  assign o_ctrl_wb  = r_ctrl_wb;
  assign o_ctrl_mem = r_ctrl_mem;
  assign o_ctrl_ex  = r_ctrl_ex;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, ALU capture, load-use
// stall, hazard exceptions, flush priority, immediate extension and freeze.
`timescale 1ns/1ps
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        i_reset, i_enable, i_flush, i_valid;
  logic [31:0] i_data_rs, i_data_rt, i_instr, i_pc_next;
  logic        i_uses_rt, i_imm_zext;
  logic [1:0]  i_ctrl_wb, i_ctrl_mem;
  logic [6:0]  i_ctrl_ex;
  logic        o_stall, o_valid;
  logic [31:0] o_data_rs, o_data_rt, o_imm, o_pc_next;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [1:0]  o_ctrl_wb, o_ctrl_mem;
  logic [6:0]  o_ctrl_ex;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] ADD3_1_2 = 32'h00221820;
  localparam logic [31:0] ADD5_4_2 = 32'h00822820;
  localparam logic [31:0] ADD5_2_4 = 32'h00442820;
  localparam logic [31:0] ADD5_0_0 = 32'h00002820;
  localparam logic [31:0] LW4_1    = 32'h8C240000;
  localparam logic [31:0] LW0_1    = 32'h8C200000;
  localparam logic [31:0] LW5_4    = 32'h8C850000;
  localparam logic [31:0] ADDI4_1  = 32'h20240005;
  localparam logic [31:0] ADDI_NEG = 32'h20228000;
  localparam logic [31:0] ORI_8000 = 32'h34228000;

  localparam logic [1:0] WB_ALU  = 2'b10;
  localparam logic [1:0] WB_LW   = 2'b11;
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_LW  = 2'b10;
  localparam logic [6:0] EX_R    = 7'h12;
  localparam logic [6:0] EX_I    = 7'h40;

  id_ex_stage dut (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .i_data_rs  (i_data_rs),
    .i_data_rt  (i_data_rt),
    .i_instr    (i_instr),
    .i_pc_next  (i_pc_next),
    .i_uses_rt  (i_uses_rt),
    .i_imm_zext (i_imm_zext),
    .i_ctrl_wb  (i_ctrl_wb),
    .i_ctrl_mem (i_ctrl_mem),
    .i_ctrl_ex  (i_ctrl_ex),
    .o_stall    (o_stall),
    .o_valid    (o_valid),
    .o_data_rs  (o_data_rs),
    .o_data_rt  (o_data_rt),
    .o_imm      (o_imm),
    .o_rs       (o_rs),
    .o_rt       (o_rt),
    .o_rd       (o_rd),
    .o_shamt    (o_shamt),
    .o_pc_next  (o_pc_next),
    .o_ctrl_wb  (o_ctrl_wb),
    .o_ctrl_mem (o_ctrl_mem),
    .o_ctrl_ex  (o_ctrl_ex)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] pc,
                       input logic uses_rt, input logic zext,
                       input logic [1:0] wb, input logic [1:0] mem,
                       input logic [6:0] ex, input logic valid);
    i_instr    = instr;
    i_data_rs  = rs;
    i_data_rt  = rt;
    i_pc_next  = pc;
    i_uses_rt  = uses_rt;
    i_imm_zext = zext;
    i_ctrl_wb  = wb;
    i_ctrl_mem = mem;
    i_ctrl_ex  = ex;
    i_valid    = valid;
  endtask

  task automatic test_reset();
    logic [169:0] all_out;
    i_reset = 1'b1; i_enable = 1'b1; i_flush = 1'b0;
    drive(ADD3_1_2, 32'h5, 32'h7, 32'h100, 1'b1, 1'b0, WB_ALU, MEM_NONE, EX_R, 1'b1);
    #1;
    all_out = {o_stall, o_valid, o_data_rs, o_data_rt, o_imm, o_rs, o_rt, o_rd,
               o_shamt, o_pc_next, o_ctrl_wb, o_ctrl_mem, o_ctrl_ex};
    n_cmp++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL reset_init: got %h want 0", all_out);
    end
    @(negedge clk);
    i_reset = 1'b0;
    step();
    n_cmp++;
    if (o_valid !== 1'b1) begin
      n_err++; $display("FAIL reset_preload_valid: got %b want 1", o_valid);
    end
    #2 i_reset = 1'b1;
    #1;
    all_out = {o_stall, o_valid, o_data_rs, o_data_rt, o_imm, o_rs, o_rt, o_rd,
               o_shamt, o_pc_next, o_ctrl_wb, o_ctrl_mem, o_ctrl_ex};
    n_cmp++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL reset_midrun: got %h want 0", all_out);
    end
    @(negedge clk);
    i_reset = 1'b0;
    i_valid = 1'b0;
    step();
  endtask

  task automatic test_alu();
    drive(ADD3_1_2, 32'h5, 32'h7, 32'h104, 1'b1, 1'b0, WB_ALU, MEM_NONE, EX_R, 1'b1);
    step();
    n_cmp++;
    if (o_data_rs !== 32'h5) begin n_err++; $display("FAIL alu_data_rs: got %h want 5", o_data_rs); end
    n_cmp++;
    if (o_data_rt !== 32'h7) begin n_err++; $display("FAIL alu_data_rt: got %h want 7", o_data_rt); end
    n_cmp++;
    if ({o_rs, o_rt, o_rd, o_shamt} !== {5'd1, 5'd2, 5'd3, 5'd0}) begin
      n_err++; $display("FAIL alu_fields: got %h want %h", {o_rs, o_rt, o_rd, o_shamt}, {5'd1, 5'd2, 5'd3, 5'd0});
    end
    n_cmp++;
    if ({o_valid, o_stall} !== 2'b10) begin n_err++; $display("FAIL alu_valid_stall: got %b want 10", {o_valid, o_stall}); end
    n_cmp++;
    if ({o_ctrl_wb, o_ctrl_mem, o_ctrl_ex} !== {WB_ALU, MEM_NONE, EX_R}) begin
      n_err++; $display("FAIL alu_ctrl: got %h want %h", {o_ctrl_wb, o_ctrl_mem, o_ctrl_ex}, {WB_ALU, MEM_NONE, EX_R});
    end
    n_cmp++;
    if ({o_pc_next, o_imm} !== {32'h104, 32'h00001820}) begin
      n_err++; $display("FAIL alu_pc_imm: got %h want %h", {o_pc_next, o_imm}, {32'h104, 32'h00001820});
    end
  endtask

  task automatic test_load_use();
    drive(LW4_1, 32'h100, 32'h0, 32'h108, 1'b0, 1'b0, WB_LW, MEM_LW, EX_I, 1'b1);
    step();
    drive(ADD5_4_2, 32'h11, 32'h22, 32'h10C, 1'b1, 1'b0, WB_ALU, MEM_NONE, EX_R, 1'b1);
    #1;
    n_cmp++;
    if (o_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", o_stall); end
    step();
    n_cmp++;
    if ({o_valid, o_ctrl_wb, o_ctrl_mem, o_ctrl_ex} !== 12'h0) begin
      n_err++; $display("FAIL lu_bubble: got %h want 0", {o_valid, o_ctrl_wb, o_ctrl_mem, o_ctrl_ex});
    end
    n_cmp++;
    if (o_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_drop: got %b want 0", o_stall); end
    step();
    n_cmp++;
    if ({o_valid, o_rd, o_data_rs} !== {1'b1, 5'd5, 32'h11}) begin
      n_err++; $display("FAIL lu_add_enters: got %h want %h", {o_valid, o_rd, o_data_rs}, {1'b1, 5'd5, 32'h11});
    end
  endtask

  task automatic test_back_to_back();
    drive(LW4_1, 32'h100, 32'h0, 32'h110, 1'b0, 1'b0, WB_LW, MEM_LW, EX_I, 1'b1);
    step();
    drive(LW5_4, 32'h200, 32'h0, 32'h114, 1'b0, 1'b0, WB_LW, MEM_LW, EX_I, 1'b1);
    #1;
    n_cmp++;
    if (o_stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall: got %b want 1", o_stall); end
    step();
    n_cmp++;
    if ({o_valid, o_stall} !== 2'b00) begin n_err++; $display("FAIL b2b_bubble: got %b want 00", {o_valid, o_stall}); end
    step();
    n_cmp++;
    if ({o_valid, o_rt, o_ctrl_mem} !== {1'b1, 5'd5, MEM_LW}) begin
      n_err++; $display("FAIL b2b_lw_enters: got %h want %h", {o_valid, o_rt, o_ctrl_mem}, {1'b1, 5'd5, MEM_LW});
    end
    n_cmp++;
    if (o_stall !== 1'b0) begin n_err++; $display("FAIL b2b_no_refire: got %b want 0", o_stall); end
  endtask

  task automatic test_no_stall();
    drive(LW0_1, 32'h100, 32'h0, 32'h120, 1'b0, 1'b0, WB_LW, MEM_LW, EX_I, 1'b1);
    step();
    drive(ADD5_0_0, 32'h0, 32'h0, 32'h124, 1'b1, 1'b0, WB_ALU, MEM_NONE, EX_R, 1'b1);
    #1;
    n_cmp++;
    if (o_stall !== 1'b0) begin n_err++; $display("FAIL ns_lw_r0: got %b want 0", o_stall); end
    drive(LW4_1, 32'h100, 32'h0, 32'h128, 1'b0, 1'b0, WB_LW, MEM_LW, EX_I, 1'b1);
    step();
    drive(ADDI4_1, 32'h9, 32'h0, 32'h12C, 1'b0, 1'b0, WB_ALU, MEM_NONE, EX_I, 1'b1);
    #1;
    n_cmp++;
    if (o_stall !== 1'b0) begin n_err++; $display("FAIL ns_addi_rt_unused: got %b want 0", o_stall); end
    drive(ADD5_2_4, 32'h9, 32'h0, 32'h12C, 1'b1, 1'b0, WB_ALU, MEM_NONE, EX_R, 1'b1);
    #1;
    n_cmp++;
    if (o_stall !== 1'b1) begin n_err++; $display("FAIL ns_rt_match: got %b want 1", o_stall); end
    drive(ADD5_4_2, 32'h9, 32'h0, 32'h12C, 1'b1, 1'b0, WB_ALU, MEM_NONE, EX_R, 1'b0);
    #1;
    n_cmp++;
    if (o_stall !== 1'b0) begin n_err++; $display("FAIL ns_id_invalid: got %b want 0", o_stall); end
    step();
    n_cmp++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL ns_invalid_bubble: got %b want 0", o_valid); end
  endtask

  task automatic test_flush_stall();
    drive(LW4_1, 32'h100, 32'h0, 32'h130, 1'b0, 1'b0, WB_LW, MEM_LW, EX_I, 1'b1);
    step();
    drive(ADD5_4_2, 32'h11, 32'h22, 32'h134, 1'b1, 1'b0, WB_ALU, MEM_NONE, EX_R, 1'b1);
    i_flush = 1'b1;
    #1;
    n_cmp++;
    if (o_stall !== 1'b0) begin n_err++; $display("FAIL fs_stall_masked: got %b want 0", o_stall); end
    step();
    n_cmp++;
    if ({o_valid, o_ctrl_wb, o_ctrl_mem} !== 5'b0) begin
      n_err++; $display("FAIL fs_bubble: got %b want 0", {o_valid, o_ctrl_wb, o_ctrl_mem});
    end
    i_flush = 1'b0;
    drive(ADD3_1_2, 32'h5, 32'h7, 32'h200, 1'b1, 1'b0, WB_ALU, MEM_NONE, EX_R, 1'b1);
    #1;
    n_cmp++;
    if (o_stall !== 1'b0) begin n_err++; $display("FAIL fs_target_nostall: got %b want 0", o_stall); end
    step();
    n_cmp++;
    if ({o_valid, o_rd, o_pc_next} !== {1'b1, 5'd3, 32'h200}) begin
      n_err++; $display("FAIL fs_target_enters: got %h want %h", {o_valid, o_rd, o_pc_next}, {1'b1, 5'd3, 32'h200});
    end
  endtask

  task automatic test_imm_enable();
    drive(ADDI_NEG, 32'h1, 32'h0, 32'h300, 1'b0, 1'b0, WB_ALU, MEM_NONE, EX_I, 1'b1);
    step();
    n_cmp++;
    if (o_imm !== 32'hFFFF8000) begin n_err++; $display("FAIL imm_sext: got %h want FFFF8000", o_imm); end
    drive(ORI_8000, 32'h1, 32'h0, 32'h304, 1'b0, 1'b1, WB_ALU, MEM_NONE, EX_I, 1'b1);
    step();
    n_cmp++;
    if (o_imm !== 32'h00008000) begin n_err++; $display("FAIL imm_zext: got %h want 00008000", o_imm); end
    drive(LW4_1, 32'h100, 32'h0, 32'h308, 1'b0, 1'b0, WB_LW, MEM_LW, EX_I, 1'b1);
    step();
    i_enable = 1'b0;
    drive(ADD5_4_2, 32'h33, 32'h44, 32'h30C, 1'b1, 1'b0, WB_ALU, MEM_NONE, EX_R, 1'b1);
    #1;
    n_cmp++;
    if (o_stall !== 1'b1) begin n_err++; $display("FAIL en_stall_held: got %b want 1", o_stall); end
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if ({o_valid, o_rt, o_ctrl_mem, o_pc_next, o_data_rs} !== {1'b1, 5'd4, MEM_LW, 32'h308, 32'h100}) begin
      n_err++; $display("FAIL en_frozen: got %h want %h", {o_valid, o_rt, o_ctrl_mem, o_pc_next, o_data_rs},
                        {1'b1, 5'd4, MEM_LW, 32'h308, 32'h100});
    end
    n_cmp++;
    if (o_stall !== 1'b1) begin n_err++; $display("FAIL en_frozen_stall: got %b want 1", o_stall); end
    i_enable = 1'b1;
    step();
    n_cmp++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL en_resume_bubble: got %b want 0", o_valid); end
    step();
    n_cmp++;
    if ({o_valid, o_rd, o_data_rs} !== {1'b1, 5'd5, 32'h33}) begin
      n_err++; $display("FAIL en_resume_add: got %h want %h", {o_valid, o_rd, o_data_rs}, {1'b1, 5'd5, 32'h33});
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_use();
    test_back_to_back();
    test_no_stall();
    test_flush_stall();
    test_imm_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
